board_renderer: RTL and testbench

Playfield renderer and locked-cell store; the consumer of the falling-piece outputs (four block X/Y positions plus palette colour) from the game-logic block. It owns the colour memory of settled cells, commits a piece into it on request, and, for every pixel the VGA controller scans, returns a 4-bit palette index. The palette/VGA output stage sits downstream.

---
 rtl/tetris_pkg.sv | 11 +
 rtl/board_renderer_if.sv | 21 ++
 rtl/cell_color_ram.sv | 36 +++
 rtl/board_renderer.sv | 133 +++++++++++++
 tb/tb_board_renderer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/tetris_pkg.sv
// tetris_pkg: shared board geometry, cell/colour types and renderer control states
package tetris_pkg;
  localparam int BOARD_W = 12;
  localparam int BOARD_H = 19;
  typedef logic [3:0] color_t;
  typedef logic [5:0] col_t;
  typedef logic [6:0] row_t;
  localparam color_t BORDER_IDX = 4'd15;
  localparam color_t EMPTY_IDX = 4'd0;
  typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_CLEAR} state_t;
endpackage

// File: rtl/board_renderer_if.sv
// board_renderer_if: piece inputs, scan position, commit/clear handshake and pixel output
interface board_renderer_if;
  import tetris_pkg::*;
  logic frame_clk;
  logic [9:0] DrawX, DrawY;
  col_t blockX1Pos, blockX2Pos, blockX3Pos, blockX4Pos;
  row_t blockY1Pos, blockY2Pos, blockY3Pos, blockY4Pos;
  color_t blockColor;
  logic lock_valid, lock_ready, clear_all;
  color_t pixel_color;
  modport master (
    output frame_clk, DrawX, DrawY, blockX1Pos, blockX2Pos, blockX3Pos, blockX4Pos,
    output blockY1Pos, blockY2Pos, blockY3Pos, blockY4Pos, blockColor, lock_valid, clear_all,
    input lock_ready, pixel_color
  );
  modport slave (
    input frame_clk, DrawX, DrawY, blockX1Pos, blockX2Pos, blockX3Pos, blockX4Pos,
    input blockY1Pos, blockY2Pos, blockY3Pos, blockY4Pos, blockColor, lock_valid, clear_all,
    output lock_ready, pixel_color
  );
endinterface

// File: rtl/cell_color_ram.sv
// cell_color_ram: settled-cell colour store, 1R1W, registered read returns pre-write data
module cell_color_ram import tetris_pkg::*; #(
  parameter int W = 12,
  parameter int H = 19
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_we,
  input  logic   i_clr,
  input  row_t   i_wrow,
  input  col_t   i_wcol,
  input  color_t i_wdata,
  input  row_t   i_rrow,
  input  col_t   i_rcol,
  output color_t o_rdata
);
  localparam int AW = $clog2(W * H);
  color_t r_mem [W*H];
  logic [AW-1:0] w_waddr, w_raddr;
  assign w_waddr = AW'(i_wrow * W + i_wcol);
  assign w_raddr = AW'(i_rrow * W + i_rcol);
  // i_clr turns the write into a whole-row wipe at i_wrow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rdata <= '0;
      for (int a = 0; a < W * H; a++) r_mem[AW'(a)] <= '0;
    end else begin
      o_rdata <= r_mem[w_raddr];
      if (i_we && i_clr) begin
        for (int c = 0; c < W; c++) r_mem[AW'(i_wrow * W + c)] <= '0;
      end else if (i_we) begin
        r_mem[w_waddr] <= i_wdata;
      end
    end
  end
endmodule

// File: rtl/board_renderer.sv
// board_renderer: locked-cell store with commit/clear walker and 2-cycle pixel classifier
module board_renderer #(
  parameter int BOARD_W    = 12,
  parameter int BOARD_H    = 19,
  parameter int CELL_SHIFT = 4,
  parameter int ORIGIN_X   = 224,
  parameter int ORIGIN_Y   = 32,
  parameter int BORDER_IDX = 15
) (
  input logic Clk,
  input logic Reset_n,
  board_renderer_if.slave bus
);
  import tetris_pkg::*;
  localparam logic signed [10:0] L_W = 11'(BOARD_W);
  localparam logic signed [10:0] L_H = 11'(BOARD_H);
  localparam logic signed [10:0] L_M1 = -11'sd1;
  localparam row_t LAST_ROW = row_t'(BOARD_H - 1);
  logic r_f1, r_f2, r_f3;
  col_t r_sx [4];
  row_t r_sy [4];
  color_t r_sc;
  col_t w_lx [4];
  row_t w_ly [4];
  state_t r_st, w_nx;
  logic [1:0] r_idx;
  row_t r_row;
  col_t r_cx [4];
  row_t r_cy [4];
  color_t r_cc;
  logic w_we, w_clr;
  row_t w_wrow, w_rrow;
  col_t w_wcol, w_rcol;
  logic signed [10:0] w_rx, w_ry, w_col, w_row;
  logic w_in, w_bd, w_hit;
  logic r_in1, r_bd1, r_hit1;
  color_t r_hc1, w_rdata;
  assign w_lx = '{bus.blockX1Pos, bus.blockX2Pos, bus.blockX3Pos, bus.blockX4Pos};
  assign w_ly = '{bus.blockY1Pos, bus.blockY2Pos, bus.blockY3Pos, bus.blockY4Pos};
  // shadow piece only changes on a synchronised frame_clk rising edge
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      {r_f1, r_f2, r_f3} <= '0;
      r_sc <= '0;
      for (int i = 0; i < 4; i++) begin
        r_sx[i] <= '0;
        r_sy[i] <= '0;
      end
    end else begin
      r_f1 <= bus.frame_clk;
      r_f2 <= r_f1;
      r_f3 <= r_f2;
      if (r_f2 && !r_f3) begin
        r_sx <= w_lx;
        r_sy <= w_ly;
        r_sc <= bus.blockColor;
      end
    end
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_st <= S_IDLE;
      r_idx <= '0;
      r_row <= '0;
      r_cc <= '0;
      for (int i = 0; i < 4; i++) begin
        r_cx[i] <= '0;
        r_cy[i] <= '0;
      end
    end else begin
      r_st <= w_nx;
      r_idx <= r_st == S_COMMIT ? r_idx + 2'd1 : 2'd0;
      r_row <= r_st == S_CLEAR ? r_row + 7'd1 : 7'd0;
      if (r_st == S_IDLE && bus.lock_valid && !bus.clear_all) begin
        r_cx <= w_lx;
        r_cy <= w_ly;
        r_cc <= bus.blockColor;
      end
    end
  end
  always_comb begin
    w_nx = r_st;
    w_we = 1'b0;
    w_clr = 1'b0;
    w_wrow = r_cy[r_idx];
    w_wcol = r_cx[r_idx];
    unique case (r_st)
      S_IDLE: w_nx = bus.clear_all ? S_CLEAR : bus.lock_valid ? S_COMMIT : S_IDLE;
      S_COMMIT: begin
        w_we = r_cx[r_idx] < col_t'(BOARD_W) && r_cy[r_idx] < row_t'(BOARD_H);
        w_nx = r_idx == 2'd3 ? S_IDLE : S_COMMIT;
      end
      S_CLEAR: begin
        w_we = 1'b1;
        w_clr = 1'b1;
        w_wrow = r_row;
        w_nx = r_row == LAST_ROW ? S_IDLE : S_CLEAR;
      end
      default: w_nx = S_IDLE;
    endcase
  end
  assign bus.lock_ready = r_st == S_IDLE;
  assign w_rx = signed'({1'b0, bus.DrawX}) - signed'(11'(ORIGIN_X));
  assign w_ry = signed'({1'b0, bus.DrawY}) - signed'(11'(ORIGIN_Y));
  assign w_col = w_rx >>> CELL_SHIFT;
  assign w_row = w_ry >>> CELL_SHIFT;
  assign w_in = !w_col[10] && w_col < L_W && !w_row[10] && w_row < L_H;
  assign w_bd = !w_in && w_col >= L_M1 && w_col <= L_W && w_row >= L_M1 && w_row <= L_H;
  assign w_rrow = w_in ? w_row[6:0] : '0;
  assign w_rcol = w_in ? w_col[5:0] : '0;
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < 4; i++) w_hit = w_hit | ({5'b0, r_sx[i]} == w_col && {4'b0, r_sy[i]} == w_row);
  end
  cell_color_ram #(.W(BOARD_W), .H(BOARD_H)) u_ram (
    .clk(Clk), .rst_n(Reset_n), .i_we(w_we), .i_clr(w_clr), .i_wrow(w_wrow), .i_wcol(w_wcol),
    .i_wdata(r_cc), .i_rrow(w_rrow), .i_rcol(w_rcol), .o_rdata(w_rdata)
  );
  // stage 1 registers classification; stage 2 merges with the memory read
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      {r_in1, r_bd1, r_hit1} <= '0;
      r_hc1 <= '0;
      bus.pixel_color <= '0;
    end else begin
      r_in1 <= w_in;
      r_bd1 <= w_bd;
      r_hit1 <= w_hit;
      r_hc1 <= r_sc;
      bus.pixel_color <= r_in1 ? (r_hit1 ? r_hc1 : w_rdata) : r_bd1 ? color_t'(BORDER_IDX) : EMPTY_IDX;
    end
  end
endmodule

// File: tb/tb_board_renderer.sv
// tb_board_renderer: directed plan checks plus randomized run against a cell-level board model
module tb_board_renderer;
  logic Clk = 1'b0;
  logic Reset_n = 1'b1;
  board_renderer_if bus();
  board_renderer dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));
  always #5 Clk = ~Clk;
  int errors = 0, checks = 0;
  typedef struct {int kind; int r; int c; int v;} act_t;
  act_t q[$];
  act_t a;
  int board [19][12];
  int sx [4], sy [4], sc;
  int lx [4], ly [4];
  int fh [3];
  int exp_d1, exp_out;
  bit exp_ready = 1'b1;
  bit rdy0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask
  function automatic int pix(int x, int y);
    int col, row;
    col = (x - 224) >>> 4;
    row = (y - 32) >>> 4;
    if (col >= 0 && col < 12 && row >= 0 && row < 19) begin
      for (int i = 0; i < 4; i++) if (sx[i] == col && sy[i] == row) return sc;
      return board[row][col];
    end
    if (col >= -1 && col <= 12 && row >= -1 && row <= 19) return 15;
    return 0;
  endfunction
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      foreach (board[r, c]) board[r][c] = 0;
      for (int i = 0; i < 4; i++) begin sx[i] = 0; sy[i] = 0; end
      sc = 0;
      fh = '{0, 0, 0};
      q.delete();
      exp_d1 = 0;
      exp_out = 0;
      exp_ready = 1'b1;
    end else begin
      lx = '{bus.blockX1Pos, bus.blockX2Pos, bus.blockX3Pos, bus.blockX4Pos};
      ly = '{bus.blockY1Pos, bus.blockY2Pos, bus.blockY3Pos, bus.blockY4Pos};
      exp_out = exp_d1;
      exp_d1 = pix(bus.DrawX, bus.DrawY);
      rdy0 = q.size() == 0;
      if (!rdy0) begin
        a = q.pop_front();
        if (a.kind == 1) board[a.r][a.c] = a.v;
        if (a.kind == 2) for (int c = 0; c < 12; c++) board[a.r][c] = 0;
      end
      if (fh[1] != 0 && fh[2] == 0) begin
        sx = lx;
        sy = ly;
        sc = bus.blockColor;
      end
      fh[2] = fh[1];
      fh[1] = fh[0];
      fh[0] = bus.frame_clk;
      if (rdy0 && bus.clear_all) begin
        for (int r = 0; r < 19; r++) q.push_back('{2, r, 0, 0});
      end else if (rdy0 && bus.lock_valid) begin
        for (int i = 0; i < 4; i++)
          q.push_back('{(lx[i] < 12 && ly[i] < 19) ? 1 : 0, ly[i], lx[i], bus.blockColor});
      end
      exp_ready = q.size() == 0;
    end
  end
  always @(negedge Clk) begin
    if (Reset_n) begin
      chk("pixel_model", bus.pixel_color, exp_out);
      chk("ready_model", bus.lock_ready, exp_ready);
    end
  end
  task automatic step(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask
  task automatic set_piece(input int x0, y0, x1, y1, x2, y2, x3, y3, c);
    bus.blockX1Pos = 6'(x0); bus.blockY1Pos = 7'(y0);
    bus.blockX2Pos = 6'(x1); bus.blockY2Pos = 7'(y1);
    bus.blockX3Pos = 6'(x2); bus.blockY3Pos = 7'(y2);
    bus.blockX4Pos = 6'(x3); bus.blockY4Pos = 7'(y3);
    bus.blockColor = 4'(c);
  endtask
  task automatic frame_edge();
    bus.frame_clk = 1'b1;
    step(4);
    bus.frame_clk = 1'b0;
    step(4);
  endtask
  task automatic scan(input int x, y, expv, input string name);
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    chk(name, bus.pixel_color, 32'(expv));
    step(1);
  endtask
  task automatic lock_and_watch(input string name);
    bus.lock_valid = 1'b1;
    @(posedge Clk);
    #1 bus.lock_valid = 1'b0;
    repeat (4) begin @(negedge Clk); chk({name, "_busy"}, bus.lock_ready, 0); end
    @(negedge Clk);
    chk({name, "_ready"}, bus.lock_ready, 1);
    step(1);
  endtask
  initial begin
    bus.frame_clk = 1'b0; bus.DrawX = '0; bus.DrawY = '0;
    bus.lock_valid = 1'b0; bus.clear_all = 1'b0;
    set_piece(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 Reset_n = 1'b0;
    #1 chk("reset_pixel", bus.pixel_color, 0);
    chk("reset_ready", bus.lock_ready, 1);
    step(3);
    Reset_n = 1'b1;
    step(1);
    scan(232, 40, 0, "empty_cell");
    scan(220, 40, 15, "left_border");
    scan(0, 0, 0, "outside");
    set_piece(5, 0, 5, 1, 6, 1, 6, 2, 3);
    scan(304, 48, 0, "before_frame");
    frame_edge();
    scan(304, 48, 3, "shadow_piece");
    set_piece(0, 18, 1, 18, 0, 17, 1, 17, 7);
    lock_and_watch("commit");
    set_piece(10, 0, 10, 1, 11, 0, 11, 1, 2);
    frame_edge();
    scan(224, 320, 7, "locked_cell");
    scan(400, 48, 2, "new_shadow");
    set_piece(12, 5, 2, 5, 3, 5, 4, 5, 9);
    lock_and_watch("skip");
    scan(256, 112, 9, "skip_written");
    scan(224, 128, 0, "skip_no_alias");
    scan(416, 112, 15, "right_border");
    set_piece(3, 3, 4, 3, 5, 3, 6, 3, 5);
    bus.clear_all = 1'b1;
    bus.lock_valid = 1'b1;
    step(1);
    bus.clear_all = 1'b0;
    bus.lock_valid = 1'b0;
    step(3);
    bus.lock_valid = 1'b1;
    step(1);
    bus.lock_valid = 1'b0;
    chk("clear_busy", bus.lock_ready, 0);
    step(20);
    chk("clear_ready", bus.lock_ready, 1);
    scan(272, 80, 0, "clear_no_lock");
    scan(224, 320, 0, "clear_row18");
    scan(256, 112, 0, "clear_row5");
    set_piece(0, 18, 4, 10, 5, 10, 6, 10, 6);
    bus.lock_valid = 1'b1;
    step(1);
    bus.lock_valid = 1'b0;
    step(2);
    Reset_n = 1'b0;
    #1 chk("abort_pixel", bus.pixel_color, 0);
    chk("abort_ready", bus.lock_ready, 1);
    step(2);
    Reset_n = 1'b1;
    step(1);
    scan(288, 192, 0, "abort_mem");
    scan(224, 320, 0, "abort_row18");
    for (int n = 0; n < 4000; n++) begin
      bus.DrawX = 10'($urandom_range(0, 7) == 0 ? $urandom_range(0, 1023) : $urandom_range(200, 440));
      bus.DrawY = 10'($urandom_range(0, 7) == 0 ? $urandom_range(0, 1023) : $urandom_range(10, 360));
      if ($urandom_range(0, 3) == 0)
        set_piece($urandom_range(0, 13), $urandom_range(0, 20), $urandom_range(0, 13), $urandom_range(0, 20),
                  $urandom_range(0, 13), $urandom_range(0, 20), $urandom_range(0, 13), $urandom_range(0, 20),
                  $urandom_range(1, 15));
      bus.lock_valid = $urandom_range(0, 9) == 0;
      bus.clear_all = $urandom_range(0, 299) == 0;
      if ($urandom_range(0, 24) == 0) bus.frame_clk = ~bus.frame_clk;
      step(1);
    end
    bus.lock_valid = 1'b0;
    bus.clear_all = 1'b0;
    step(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
